// File: rtl/wgt_col_feeder.sv
// Weight-column feeder: fetches a K_H x K_W kernel column-major from weight SRAM,
// pushes whole columns into a PE circular weight register, then issues paced shifts.
module wgt_col_feeder #(
  parameter int K_H    = 3,
  parameter int K_W    = 3,
  parameter int ADDR_W = 12,
  parameter int STEP_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [STEP_W-1:0] num_steps,
  input  logic              abort,
  input  logic              step_i,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              clr_o,
  output logic              load_en_o,
  output logic [8*K_H-1:0]  col_data_o,
  output logic              shift_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int N  = K_H * K_W;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = (K_H > 1) ? $clog2(K_H) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_FETCH, S_DRAIN, S_RUN} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] base_q, addr_q;
  logic [STEP_W-1:0] steps_q, step_cnt_q;
  logic [KW-1:0]     k_q;
  logic [RW-1:0]     row_q, rd_row_q;
  logic              rd_en_q, rd_valid_q, abort_pend_q;
  logic              clr_q, load_q, shift_q, busy_q, done_q;
  logic [7:0]        col_buf_q [K_H];
  logic [8*K_H-1:0]  col_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      addr_q       <= '0;
      steps_q      <= '0;
      step_cnt_q   <= '0;
      k_q          <= '0;
      row_q        <= '0;
      rd_row_q     <= '0;
      rd_en_q      <= 1'b0;
      rd_valid_q   <= 1'b0;
      abort_pend_q <= 1'b0;
      clr_q        <= 1'b0;
      load_q       <= 1'b0;
      shift_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      col_data_q   <= '0;
      // NOTE: col_buf is a handful of flops, not a RAM, so resetting it is cheap and keeps col_data_o deterministic.
      for (int r = 0; r < K_H; r++) col_buf_q[r] <= '0;
    end else begin
      // NOTE: every state update uses <= so all reads below see the pre-edge values.
      clr_q        <= abort_pend_q;
      abort_pend_q <= 1'b0;
      load_q       <= 1'b0;
      shift_q      <= 1'b0;
      done_q       <= 1'b0;

      // Read pipeline: data for the read issued last cycle is on mem_rdata now.
      rd_valid_q <= rd_en_q;
      rd_row_q   <= row_q;
      if (rd_valid_q) begin
        col_buf_q[rd_row_q] <= mem_rdata;
        if (rd_row_q == RW'(K_H - 1)) begin
          load_q <= 1'b1;
          for (int r = 0; r < K_H; r++)
            col_data_q[8*r +: 8] <= (r == K_H - 1) ? mem_rdata : col_buf_q[r];
        end
      end

      unique case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          if (start) begin
            state_q    <= S_CLR;
            clr_q      <= 1'b1;
            busy_q     <= 1'b1;
            base_q     <= base_addr;
            steps_q    <= num_steps;
            step_cnt_q <= '0;
          end
        end
        S_CLR: begin
          state_q <= S_FETCH;
          rd_en_q <= 1'b1;
          addr_q  <= base_q;
          k_q     <= '0;
          row_q   <= '0;
        end
        S_FETCH: begin
          if (k_q == KW'(N - 1)) begin
            rd_en_q <= 1'b0;
            state_q <= S_DRAIN;
          end else begin
            addr_q <= addr_q + 1'b1;
            k_q    <= k_q + 1'b1;
            row_q  <= (row_q == RW'(K_H - 1)) ? '0 : row_q + 1'b1;
          end
        end
        S_DRAIN: begin
          // Zero rotations: the done pulse lands on the same cycle as the last push.
          if (steps_q == '0) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (step_cnt_q == steps_q) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else if (step_i) begin
            shift_q    <= 1'b1;
            step_cnt_q <= step_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Abort overrides everything above, including in-flight read data.
      if (abort && state_q != S_IDLE) begin
        state_q      <= S_IDLE;
        rd_en_q      <= 1'b0;
        rd_valid_q   <= 1'b0;
        load_q       <= 1'b0;
        shift_q      <= 1'b0;
        done_q       <= 1'b0;
        busy_q       <= 1'b0;
        abort_pend_q <= 1'b1;
      end
    end
  end

  assign mem_rd_en  = rd_en_q;
  assign mem_addr   = addr_q;
  assign clr_o      = clr_q;
  assign load_en_o  = load_q;
  assign col_data_o = col_data_q;
  assign shift_o    = shift_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_wgt_col_feeder.sv
// Directed bench for wgt_col_feeder: cycle-accurate checks of fetch, push, shift,
// abort and reset behaviour against a small SRAM model with 1-cycle read latency.
module tb_wgt_col_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] base_addr = '0;
  logic [9:0]  num_steps = '0;
  logic        abort = 1'b0;
  logic        step_i = 1'b0;
  logic        mem_rd_en;
  logic [11:0] mem_addr;
  logic [7:0]  mem_rdata = '0;
  logic        clr_o, load_en_o, shift_o, busy_o, done_o;
  logic [23:0] col_data_o;

  logic [7:0]  mem [0:4095];
  int          n_checks = 0;
  int          n_fail = 0;

  wgt_col_feeder #(.K_H(3), .K_W(3), .ADDR_W(12), .STEP_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_steps(num_steps), .abort(abort), .step_i(step_i),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .clr_o(clr_o), .load_en_o(load_en_o), .col_data_o(col_data_o),
    .shift_o(shift_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a kernel load and checks cycles T+1..T+12; returns positioned in cycle T+12.
  task automatic fetch_phase(input logic [11:0] b, input logic [9:0] s, input int glitch_cyc);
    logic        e;
    logic [11:0] ea, a0, a1, a2;
    logic [23:0] ecol;
    int          c;
    base_addr = b;
    num_steps = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (cyc == glitch_cyc) begin
        start = 1'b1; base_addr = 12'h200; num_steps = 10'd5;
      end else if (cyc == glitch_cyc + 1) begin
        start = 1'b0; base_addr = b; num_steps = s;
      end
      e = (cyc == 1);
      n_checks++;
      if (clr_o !== e) begin n_fail++; $display("FAIL clr_o cyc T+%0d: got %b expected %b", cyc, clr_o, e); end
      e = (cyc >= 2 && cyc <= 10);
      n_checks++;
      if (mem_rd_en !== e) begin n_fail++; $display("FAIL mem_rd_en cyc T+%0d: got %b expected %b", cyc, mem_rd_en, e); end
      if (e) begin
        ea = b + 12'(cyc - 2);
        n_checks++;
        if (mem_addr !== ea) begin n_fail++; $display("FAIL mem_addr cyc T+%0d: got %h expected %h", cyc, mem_addr, ea); end
      end
      e = (cyc == 6 || cyc == 9 || cyc == 12);
      n_checks++;
      if (load_en_o !== e) begin n_fail++; $display("FAIL load_en_o cyc T+%0d: got %b expected %b", cyc, load_en_o, e); end
      if (e) begin
        c = (cyc - 6) / 3;
        a0 = b + 12'(3 * c);
        a1 = b + 12'(3 * c + 1);
        a2 = b + 12'(3 * c + 2);
        ecol = {mem[a2], mem[a1], mem[a0]};
        n_checks++;
        if (col_data_o !== ecol) begin n_fail++; $display("FAIL col_data_o col %0d: got %h expected %h", c, col_data_o, ecol); end
      end
      n_checks++;
      if (shift_o !== 1'b0) begin n_fail++; $display("FAIL shift_o during fetch cyc T+%0d: got %b expected 0", cyc, shift_o); end
      if (cyc <= 11) begin
        n_checks++;
        if (busy_o !== 1'b1 || done_o !== 1'b0)
          begin n_fail++; $display("FAIL busy/done cyc T+%0d: got %b/%b expected 1/0", cyc, busy_o, done_o); end
      end
      if (cyc < 12) tick();
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({clr_o, load_en_o, shift_o, busy_o, done_o, mem_rd_en} !== 6'b0 || col_data_o !== 24'h0 || mem_addr !== 12'h0)
      begin n_fail++; $display("FAIL reset outputs: got ctl=%b col=%h addr=%h expected all 0",
        {clr_o, load_en_o, shift_o, busy_o, done_o, mem_rd_en}, col_data_o, mem_addr); end
    rst_n = 1'b1;
    tick();
    tick();
    n_checks++;
    if (clr_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL post-reset clr/busy: got %b/%b expected 0/0", clr_o, busy_o); end
  endtask

  task automatic test_basic();
    fetch_phase(12'h010, 10'd0, 0);
    n_checks++;
    if (col_data_o !== 24'h090807) begin n_fail++; $display("FAIL basic last column: got %h expected 090807", col_data_o); end
    n_checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b1) begin n_fail++; $display("FAIL basic done/busy T+12: got %b/%b expected 1/1", done_o, busy_o); end
    tick();
    n_checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || load_en_o !== 1'b0)
      begin n_fail++; $display("FAIL basic T+13 done/busy/load: got %b/%b/%b expected 0/0/0", done_o, busy_o, load_en_o); end
    n_checks++;
    if (col_data_o !== 24'h090807) begin n_fail++; $display("FAIL basic col hold: got %h expected 090807", col_data_o); end
  endtask

  task automatic test_steps_held();
    logic es, ed;
    fetch_phase(12'h010, 10'd4, 0);
    n_checks++;
    if (done_o !== 1'b0) begin n_fail++; $display("FAIL held done at RUN entry: got %b expected 0", done_o); end
    step_i = 1'b1;
    for (int cyc = 13; cyc <= 18; cyc++) begin
      tick();
      es = (cyc >= 13 && cyc <= 16);
      ed = (cyc == 17);
      n_checks++;
      if (shift_o !== es || done_o !== ed)
        begin n_fail++; $display("FAIL held shift/done T+%0d: got %b/%b expected %b/%b", cyc, shift_o, done_o, es, ed); end
      n_checks++;
      if (busy_o !== (cyc <= 17)) begin n_fail++; $display("FAIL held busy T+%0d: got %b expected %b", cyc, busy_o, cyc <= 17); end
    end
    step_i = 1'b0;
  endtask

  task automatic test_step_toggle();
    logic es, ed;
    fetch_phase(12'h010, 10'd2, 0);
    for (int cyc = 13; cyc <= 17; cyc++) begin
      step_i = (cyc == 13 || cyc == 15);
      tick();
      es = (cyc == 13 || cyc == 15);
      ed = (cyc == 16);
      n_checks++;
      if (shift_o !== es || done_o !== ed)
        begin n_fail++; $display("FAIL toggle shift/done T+%0d: got %b/%b expected %b/%b", cyc, shift_o, done_o, es, ed); end
    end
    step_i = 1'b0;
  endtask

  task automatic test_wrap();
    fetch_phase(12'hFFE, 10'd0, 0);
    n_checks++;
    if (col_data_o !== 24'h998877) begin n_fail++; $display("FAIL wrap last column: got %h expected 998877", col_data_o); end
    n_checks++;
    if (done_o !== 1'b1) begin n_fail++; $display("FAIL wrap done: got %b expected 1", done_o); end
    tick();
  endtask

  task automatic test_start_ignored();
    fetch_phase(12'h010, 10'd0, 4);
    n_checks++;
    if (done_o !== 1'b1) begin n_fail++; $display("FAIL ignored-start done T+12: got %b expected 1", done_o); end
    tick();
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL ignored-start busy T+13: got %b expected 0", busy_o); end
  endtask

  task automatic test_abort();
    base_addr = 12'h010;
    num_steps = 10'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    n_checks++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 12'h015)
      begin n_fail++; $display("FAIL abort T+7 read: got %b/%h expected 1/015", mem_rd_en, mem_addr); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (mem_rd_en !== 1'b0 || busy_o !== 1'b0 || clr_o !== 1'b0)
      begin n_fail++; $display("FAIL abort T+8 rd/busy/clr: got %b/%b/%b expected 0/0/0", mem_rd_en, busy_o, clr_o); end
    tick();
    n_checks++;
    if (clr_o !== 1'b1 || load_en_o !== 1'b0 || done_o !== 1'b0)
      begin n_fail++; $display("FAIL abort T+9 clr/load/done: got %b/%b/%b expected 1/0/0", clr_o, load_en_o, done_o); end
    for (int cyc = 10; cyc <= 14; cyc++) begin
      tick();
      n_checks++;
      if ({clr_o, load_en_o, done_o, mem_rd_en, busy_o} !== 5'b0)
        begin n_fail++; $display("FAIL abort quiet T+%0d: got clr/load/done/rd/busy=%b expected 00000", cyc,
          {clr_o, load_en_o, done_o, mem_rd_en, busy_o}); end
    end
    fetch_phase(12'h010, 10'd0, 0);
    n_checks++;
    if (done_o !== 1'b1) begin n_fail++; $display("FAIL restart after abort done: got %b expected 1", done_o); end
    tick();
  endtask

  task automatic test_abort_run();
    fetch_phase(12'h010, 10'd1, 0);
    step_i = 1'b1;
    abort = 1'b1;
    tick();
    step_i = 1'b0;
    abort = 1'b0;
    n_checks++;
    if (shift_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0)
      begin n_fail++; $display("FAIL abort-vs-step T+13 shift/done/busy: got %b/%b/%b expected 0/0/0", shift_o, done_o, busy_o); end
    tick();
    n_checks++;
    if (clr_o !== 1'b1 || done_o !== 1'b0)
      begin n_fail++; $display("FAIL abort-vs-step T+14 clr/done: got %b/%b expected 1/0", clr_o, done_o); end
    tick();
  endtask

  task automatic test_reset_in_run();
    fetch_phase(12'h010, 10'd5, 0);
    step_i = 1'b1;
    tick();
    tick();
    n_checks++;
    if (shift_o !== 1'b1 || busy_o !== 1'b1) begin n_fail++; $display("FAIL pre-reset shift/busy: got %b/%b expected 1/1", shift_o, busy_o); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({clr_o, load_en_o, shift_o, busy_o, done_o, mem_rd_en} !== 6'b0 || col_data_o !== 24'h0 || mem_addr !== 12'h0)
      begin n_fail++; $display("FAIL async reset in RUN: got ctl=%b col=%h addr=%h expected all 0",
        {clr_o, load_en_o, shift_o, busy_o, done_o, mem_rd_en}, col_data_o, mem_addr); end
    step_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    n_checks++;
    if (clr_o !== 1'b0 || busy_o !== 1'b0 || shift_o !== 1'b0)
      begin n_fail++; $display("FAIL after reset release clr/busy/shift: got %b/%b/%b expected 0/0/0", clr_o, busy_o, shift_o); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'hEE;
    for (int k = 0; k < 9; k++) begin
      mem[12'h010 + 12'(k)] = 8'(k + 1);
      mem[12'hFFE + 12'(k)] = 8'(8'h11 * (k + 1));
    end
    test_reset();
    test_basic();
    test_steps_held();
    test_step_toggle();
    test_wrap();
    test_start_ignored();
    test_abort();
    test_abort_run();
    test_reset_in_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wgt_col_feeder.md
# wgt_col_feeder

Weight-column feeder that drives the PE circular weight register from weight SRAM. On `start` it clears the register and fetches a K_H×K_W 8-bit kernel from SRAM, one byte per cycle. It assembles each column and pushes it with a one-cycle `load_en_o`. It then issues one `shift_o` per `step_i` request until the programmed number of rotations is reached, and signals `done_o`. It sits between the layer controller / weight SRAM and one PE's circular weight register.

## Interface
- K_H, 3, kernel height (rows per column, width of column bus)
- K_W, 3, kernel width (columns per kernel)
- ADDR_W, 12, weight SRAM address width
- STEP_W, 10, width of rotation counter
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request; accepted only in IDLE
- base_addr  in  ADDR_W  kernel base address, sampled on accepted start
- num_steps  in  STEP_W  number of shifts to issue, sampled on accepted start
- abort  in  1  terminate current operation
- step_i  in  1  request one circular shift (RUN state only)
- mem_rd_en  out  1  SRAM read strobe
- mem_addr  out  ADDR_W  SRAM read address
- mem_rdata  in  8  SRAM read data, valid exactly 1 cycle after mem_rd_en
- clr_o  out  1  clear pulse to circular register
- load_en_o  out  1  column push strobe
- col_data_o  out  8×K_H  column data, element r = kernel row r
- shift_o  out  1  circular shift strobe
- busy_o  out  1  high while not IDLE
- done_o  out  1  one-cycle completion pulse

## Operation
- States: IDLE → CLR → FETCH → DRAIN → RUN → IDLE.
- IDLE: accepted start latches base_addr and num_steps and moves to CLR.
- CLR: clr_o=1 for one cycle, then FETCH.
- FETCH: issues K_H·K_W consecutive reads, one per cycle, index k=0..K_H·K_W-1.
  - Layout is column-major: mem_addr = base_addr + k, with k = c·K_H + r.
  - The address adds modulo 2^ADDR_W, so it wraps at the top of SRAM.
- Read data for (c,r) is registered into col_buf[r] one cycle after its read.
- When r=K_H-1 is captured, load_en_o=1 for one cycle with col_data_o=col_buf. This occurs for columns c=0..K_W-1 in order.
- After K_W pushes, column 0 is at register position K_W-1 and column K_W-1 is at position 0.
- DRAIN: covers the in-flight last read and the last push, then RUN.
- RUN: each step_i=1 yields one shift_o pulse, and the step counter increments.
  - When the count equals num_steps, done_o pulses and the state returns to IDLE.
  - num_steps=0: done_o pulses on the first RUN cycle with no shift.
  - step_i outside RUN is ignored.
- shift_o and load_en_o are never high in the same cycle. clr_o is never high with either.
- abort in any non-IDLE state:
  - Next state is IDLE.
  - clr_o pulses in the following cycle.
  - mem_rd_en drops immediately in the next cycle. Pending read data is discarded, and no further load_en_o is produced.
  - No done_o.
- abort wins over a simultaneous step_i or a simultaneous final-count done.
- start outside IDLE is ignored. abort in IDLE has no effect.

## Timing
- Reset values: every output is 0, and the state is IDLE.
  - Asynchronous reset mid-operation returns to IDLE immediately, with all outputs 0.
  - After reset no clr_o is issued; the register's own reset covers it.
- Start accepted at cycle T:
  - clr_o at T+1.
  - Reads at T+2 .. T+1+K_H·K_W.
- Column c load_en_o occurs at T+2+(c+1)·K_H+1. With K_H=K_W=3: T+6, T+9, T+12.
- RUN is entered at T+3+K_H·K_W (T+12 for 3×3). The last push and RUN entry coincide.
  - step_i sampled at RUN cycle t gives shift_o at t+1.
  - done_o is asserted in the cycle after the shift_o that reached num_steps.
- busy_o is high from T+1 through the done_o cycle inclusive, then 0.
- Registered outputs throughout; col_data_o holds its value between pushes.

## Test plan
- 3×3 kernel at base 0x010 with bytes 1..9, num_steps=0, start:
  - clr_o at T+1.
  - mem_addr sequence 0x010..0x018.
  - Pushes {1,2,3}, {4,5,6}, {7,8,9} at T+6/T+9/T+12.
  - done_o at T+12, busy_o low at T+13.
- num_steps=4, step_i held high from RUN entry: exactly 4 shift_o pulses on consecutive cycles, done_o the cycle after the 4th, no 5th shift.
- step_i toggling 1,0,1,0 with num_steps=2: shift_o follows one cycle later as 1,0,1, then done_o.
- base_addr=0xFFE: addresses 0xFFE, 0xFFF, 0x000..0x006 in wrap order; data pushed correctly.
- abort at T+7, mid column 1:
  - mem_rd_en=0 from T+8.
  - No push at T+9.
  - clr_o at T+9.
  - busy_o=0 and no done_o; a new start is accepted afterwards.
- start pulse during FETCH: ignored, no address restart. rst_n asserted in RUN: all outputs 0 immediately.
